// File: rtl/pll_drp_reconfig.sv
// ----------------------------------------------------------------------------
// pll_drp_reconfig
//
// DRP initiator that changes one PLLE2 output divider at run time.  A divide
// request is latched on acceptance.  The PLL is held in reset while
// ClkReg1/ClkReg2 of the selected output are read-modify-written.  Reset is
// then released and the block waits for LOCKED.
//
// Ports
//   dclk        in   1   DRP clock, all logic on the rising edge
//   rst_n       in   1   asynchronous active-low reset
//   req_valid   in   1   request valid
//   req_ready   out  1   high only while idle; accept on valid & ready
//   req_sel     in   3   0-5 = CLKOUT0-5, 6 = CLKFBOUT, 7 = illegal
//   req_divide  in   7   new divide value 1..64 (0 or >64 illegal)
//   busy        out  1   acceptance through the done/err cycle inclusive
//   done        out  1   1-cycle pulse, reconfiguration finished and locked
//   err         out  1   1-cycle pulse, illegal request or timeout
//   daddr       out  7   DRP address
//   den         out  1   DRP enable, one cycle per access
//   dwe         out  1   DRP write enable, only with den
//   di          out  16  DRP write data
//   drp_do      in   16  DRP read data, valid with drdy
//   drdy        in   1   DRP access complete
//   pll_rst     out  1   PLL reset
//   locked      in   1   PLL locked
// ----------------------------------------------------------------------------
module pll_drp_reconfig #(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int RST_HOLD     = 4
) (
  input  logic        dclk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_sel,
  input  logic [6:0]  req_divide,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  daddr,
  output logic        den,
  output logic        dwe,
  output logic [15:0] di,
  input  logic [15:0] drp_do,
  input  logic        drdy,
  output logic        pll_rst,
  input  logic        locked
);

  // One counter serves the hold time, DRDY timeout and lock timeout, since
  // they are never active at the same time.
  localparam int MAX_A = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int MAX_T = (MAX_A > RST_HOLD) ? MAX_A : RST_HOLD;
  localparam int CW    = $clog2(MAX_T + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HOLD,
    S_RD1,
    S_W_RD1,
    S_WR1,
    S_W_WR1,
    S_RD2,
    S_W_RD2,
    S_WR2,
    S_W_WR2,
    S_LOCKW,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      sel_reg;
  logic [6:0]      div_reg;
  // Only the read bits that survive the modify step are kept:
  // {DO[15:8], DO[5:0]}.
  logic [13:0]     rdata_reg;

  logic            req_legal;
  logic [5:0]      enc_high;
  logic [5:0]      enc_low;
  logic            enc_edge;
  logic            enc_nocount;
  logic [6:0]      reg1_addr;
  logic [6:0]      reg2_addr;
  logic [15:0]     rmw1;
  logic [15:0]     rmw2;

  assign req_legal = (req_sel != 3'd7) && (req_divide != 7'd0) && (req_divide <= 7'd64);

  // --------------------------------------------------------------------------
  // Divider encoding of the latched request.  Divide-by-1 is a bypass
  // (NO_COUNT) with a nominal 1/1 count.  For 64 the high half is 32, which
  // still fits in six bits.
  // --------------------------------------------------------------------------
  always_comb begin
    if (div_reg == 7'd1) begin
      enc_high    = 6'd1;
      enc_low     = 6'd1;
      enc_edge    = 1'b0;
      enc_nocount = 1'b1;
    end else begin
      enc_high    = div_reg[6:1];
      enc_low     = 6'(div_reg - {1'b0, div_reg[6:1]});
      enc_edge    = div_reg[0];
      enc_nocount = 1'b0;
    end
  end

  // ClkReg1 address of each output; ClkReg2 always follows at +1.
  always_comb begin
    case (sel_reg)
      3'd0:    reg1_addr = 7'h08;
      3'd1:    reg1_addr = 7'h0A;
      3'd2:    reg1_addr = 7'h0C;
      3'd3:    reg1_addr = 7'h0E;
      3'd4:    reg1_addr = 7'h10;
      3'd5:    reg1_addr = 7'h06;
      3'd6:    reg1_addr = 7'h14;
      default: reg1_addr = 7'h00;
    endcase
  end

  assign reg2_addr = reg1_addr | 7'h01;

  // Keep the phase/mux bits read back, replace only the count fields.
  assign rmw1 = {rdata_reg[13:10], enc_high, enc_low};
  assign rmw2 = {rdata_reg[13:6], enc_edge, enc_nocount, rdata_reg[5:0]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Request latch and read-data capture
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg   <= '0;
      div_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      if (state_reg == S_IDLE && req_valid) begin
        sel_reg <= req_sel;
        div_reg <= req_divide;
      end
      if ((state_reg == S_W_RD1 || state_reg == S_W_RD2) && drdy) begin
        rdata_reg <= {drp_do[15:8], drp_do[5:0]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic.  In the access states the counter is loaded with 1 so
  // that in a wait state it equals the number of cycles since DEN; giving up
  // at DRDY_TIMEOUT-1 puts the ERR pulse exactly DRDY_TIMEOUT cycles after
  // DEN.  In LOCKW the counter equals the cycles since reset release, and a
  // zero count masks LOCKED during the first LOCKW cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (req_valid) begin
          state_next = req_legal ? S_HOLD : S_ERR;
        end
      end
      S_HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = S_RD1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_RD1: begin
        state_next = S_W_RD1;
        cnt_next   = CW'(1);
      end
      S_WR1: begin
        state_next = S_W_WR1;
        cnt_next   = CW'(1);
      end
      S_RD2: begin
        state_next = S_W_RD2;
        cnt_next   = CW'(1);
      end
      S_WR2: begin
        state_next = S_W_WR2;
        cnt_next   = CW'(1);
      end
      S_W_RD1, S_W_WR1, S_W_RD2, S_W_WR2: begin
        if (drdy) begin
          cnt_next = '0;
          case (state_reg)
            S_W_RD1: state_next = S_WR1;
            S_W_WR1: state_next = S_RD2;
            S_W_RD2: state_next = S_WR2;
            default: state_next = S_LOCKW;
          endcase
        end else if (cnt_reg == DRDY_LAST) begin
          state_next = S_ERR;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_LOCKW: begin
        if (cnt_reg != '0 && locked) begin
          state_next = S_DONE;
          cnt_next   = '0;
        end else if (cnt_reg == LOCK_LAST) begin
          state_next = S_ERR;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
      S_ERR: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from the registered state only, so an async reset puts
  // every output back to its idle value at once.  The PLL stays in reset from
  // HOLD through the last write; it is released on entry to LOCKW, or when an
  // error aborts the sequence.
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    daddr     = 7'h00;
    den       = 1'b0;
    dwe       = 1'b0;
    di        = 16'h0000;
    pll_rst   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_HOLD: begin
        pll_rst = 1'b1;
      end
      S_RD1: begin
        pll_rst = 1'b1;
        den     = 1'b1;
        daddr   = reg1_addr;
      end
      S_WR1: begin
        pll_rst = 1'b1;
        den     = 1'b1;
        dwe     = 1'b1;
        daddr   = reg1_addr;
        di      = rmw1;
      end
      S_RD2: begin
        pll_rst = 1'b1;
        den     = 1'b1;
        daddr   = reg2_addr;
      end
      S_WR2: begin
        pll_rst = 1'b1;
        den     = 1'b1;
        dwe     = 1'b1;
        daddr   = reg2_addr;
        di      = rmw2;
      end
      S_W_RD1, S_W_WR1, S_W_RD2, S_W_WR2: begin
        pll_rst = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// ----------------------------------------------------------------------------
// tb_pll_drp_reconfig
//
// Stimulus issues divide requests and pushes the expected DRP accesses and the
// expected final outcome into queues.  A monitor pops and compares whenever the
// DUT presents DEN or DONE/ERR.  A responder process emulates the DRP register
// file and the PLL LOCKED behaviour.
// ----------------------------------------------------------------------------
module tb_pll_drp_reconfig;

  localparam int DRDY_TO = 64;
  localparam int LOCK_TO = 4096;
  localparam int HOLD    = 4;

  logic        dclk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_sel;
  logic [6:0]  req_divide;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] drp_do;
  logic        drdy;
  logic        pll_rst;
  logic        locked;

  pll_drp_reconfig #(
    .DRDY_TIMEOUT(DRDY_TO),
    .LOCK_TIMEOUT(LOCK_TO),
    .RST_HOLD    (HOLD)
  ) dut (
    .dclk      (dclk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_divide(req_divide),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .daddr     (daddr),
    .den       (den),
    .dwe       (dwe),
    .di        (di),
    .drp_do    (drp_do),
    .drdy      (drdy),
    .pll_rst   (pll_rst),
    .locked    (locked)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  typedef struct {
    logic [6:0]  addr;
    logic        we;
    logic [15:0] data;
  } drp_t;

  // kind: 0 = DONE, 1 = ERR.  anchor: 0 none, 1 acceptance, 2 last DEN,
  // 3 PLL reset release.  lat: required cycles from the anchor.
  typedef struct {
    int kind;
    int anchor;
    int lat;
  } res_t;

  drp_t        exp_q[$];
  res_t        res_q[$];
  logic [15:0] mem [0:127];
  int          checks = 0;
  int          errors = 0;
  int          withhold_addr = -1;
  bit          hold_locked = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic bound_expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
    finish_run();
  endtask

  // ClkReg1 address per output select; ClkReg2 lives at the next address.
  function automatic int reg1_of(input int sel);
    int tbl[7] = '{'h08, 'h0A, 'h0C, 'h0E, 'h10, 'h06, 'h14};
    return tbl[sel];
  endfunction

  // Register values the PLL should end up with for divide d.
  function automatic void ref_model(input int d, input int old1, input int old2,
                                    output logic [15:0] w1, output logic [15:0] w2);
    int h, l, e, nc;
    if (d == 1) begin
      h = 1; l = 1; e = 0; nc = 1;
    end else begin
      h = d / 2; l = d - h; e = d % 2; nc = 0;
    end
    w1 = 16'((old1 & 'hF000) + h * 64 + l);
    w2 = 16'((old2 & 'hFF3F) + e * 128 + nc * 64);
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_err"},       32'(err),       0);
    chk({tag, "_den"},       32'(den),       0);
    chk({tag, "_dwe"},       32'(dwe),       0);
    chk({tag, "_daddr"},     32'(daddr),     0);
    chk({tag, "_di"},        32'(di),        0);
    chk({tag, "_pll_rst"},   32'(pll_rst),   0);
  endtask

  // mode: 0 normal, 1 withhold DRDY on the ClkReg2 read, 2 LOCKED held low,
  //       3 async reset pulse while waiting on the first write.
  task automatic issue(input int sel, input int d, input int mode);
    bit          legal;
    int          r1, r2, n;
    logic [15:0] w1, w2;
    legal = (sel < 7) && (d >= 1) && (d <= 64);
    n = 0;
    while (!req_ready) begin
      @(posedge dclk); #1;
      if (++n > 200) bound_expired("req_ready");
    end
    if (legal) begin
      r1 = reg1_of(sel);
      r2 = r1 + 1;
      ref_model(d, int'(mem[r1]), int'(mem[r2]), w1, w2);
      exp_q.push_back('{7'(r1), 1'b0, 16'h0});
      exp_q.push_back('{7'(r1), 1'b1, w1});
      exp_q.push_back('{7'(r2), 1'b0, 16'h0});
      if (mode == 1) begin
        withhold_addr = r2;
        res_q.push_back('{1, 2, DRDY_TO});
      end else begin
        exp_q.push_back('{7'(r2), 1'b1, w2});
        if (mode == 2) begin
          hold_locked = 1'b1;
          res_q.push_back('{1, 3, LOCK_TO});
        end else begin
          res_q.push_back('{0, 0, 0});
        end
      end
    end else begin
      res_q.push_back('{1, 1, 1});
    end
    req_valid  = 1'b1;
    req_sel    = 3'(sel);
    req_divide = 7'(d);
    @(posedge dclk); #1;
    req_valid  = 1'b0;
    req_sel    = 3'($urandom);
    req_divide = 7'($urandom);
    if (mode == 3) begin
      n = 0;
      while (!(den && dwe)) begin
        @(posedge dclk); #1;
        if (++n > 100) bound_expired("first_write");
      end
      @(posedge dclk); #1;
      rst_n = 1'b0;
      #1;
      check_reset("midop");
      exp_q.delete();
      res_q.delete();
      @(posedge dclk); #1;
      rst_n = 1'b1;
    end else begin
      n = 0;
      while (busy) begin
        @(posedge dclk); #1;
        if (++n > LOCK_TO + 2000) bound_expired("busy");
      end
    end
    if (legal && mode != 2 && mode != 1 && mode != 3) begin
      mem[r1] = w1;
      mem[r2] = w2;
    end else if (legal) begin
      mem[r1] = w1;
      if (mode == 2) mem[r2] = w2;
    end
    chk("drp_left", 32'(exp_q.size()), 0);
    chk("res_left", 32'(res_q.size()), 0);
    $display("txn sel=%0d div=%0d mode=%0d errors=%0d checks=%0d", sel, d, mode, errors, checks);
    withhold_addr = -1;
    hold_locked   = 1'b0;
  endtask

  // DRP register file and LOCKED model
  initial begin
    int          pend;
    bit          outstanding;
    int          lock_cnt;
    logic [15:0] rsp;
    drdy   = 1'b0;
    drp_do = 16'h0;
    locked = 1'b1;
    pend = 0; outstanding = 0; lock_cnt = 0; rsp = 16'h0;
    forever begin
      @(negedge dclk);
      if (!rst_n) begin
        pend = 0;
        outstanding = 0;
        drdy = 1'b0;
      end else begin
        drdy = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            drdy = 1'b1;
            drp_do = rsp;
            outstanding = 0;
          end
        end else if (!outstanding && !den && withhold_addr < 0 && $urandom_range(0, 7) == 0) begin
          // Stray DRDY with junk data while no access is pending
          drdy = 1'b1;
          drp_do = 16'($urandom);
        end
        if (den) begin
          chk("den_before_drdy", 32'(outstanding), 0);
          if (!(dwe == 1'b0 && int'(daddr) == withhold_addr)) begin
            outstanding = 1;
            pend = $urandom_range(1, 4);
            rsp = dwe ? 16'($urandom) : mem[daddr];
          end
        end
      end
      if (pll_rst) begin
        locked = 1'b0;
        lock_cnt = $urandom_range(1, 20);
      end else if (!locked && !hold_locked) begin
        if (lock_cnt > 0) lock_cnt--;
        else locked = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    int   cyc, acc_cyc, den_cyc, fall_cyc, ref_cyc;
    bit   prev_rst, idle_next;
    drp_t e;
    res_t r;
    cyc = 0; acc_cyc = 0; den_cyc = 0; fall_cyc = 0;
    prev_rst = 0; idle_next = 0;
    forever begin
      @(negedge dclk);
      cyc++;
      if (!rst_n) begin
        prev_rst  = 0;
        idle_next = 0;
        continue;
      end
      if (idle_next) begin
        chk("busy_drop", 32'(busy), 0);
        chk("ready_back", 32'(req_ready), 1);
        idle_next = 0;
      end
      if (req_valid && req_ready) acc_cyc = cyc;
      if (pll_rst && !prev_rst) chk("pll_rst_only_legal", 32'(exp_q.size() != 0), 1);
      if (!pll_rst && prev_rst) fall_cyc = cyc;
      prev_rst = pll_rst;
      if (dwe && !den) chk("dwe_without_den", 32'(dwe), 0);
      if (den) begin
        den_cyc = cyc;
        chk("den_in_reset", 32'(pll_rst), 1);
        if (exp_q.size() == 0) begin
          chk("den_expected", 32'(den), 0);
        end else begin
          e = exp_q.pop_front();
          chk("daddr", 32'(daddr), 32'(e.addr));
          chk("dwe", 32'(dwe), 32'(e.we));
          if (e.we) chk("di", 32'(di), 32'(e.data));
        end
      end
      if (done || err) begin
        chk("done_err_excl", 32'(done & err), 0);
        chk("busy_at_end", 32'(busy), 1);
        chk("pll_rst_at_end", 32'(pll_rst), 0);
        if (res_q.size() == 0) begin
          chk("result_expected", 32'(done | err), 0);
        end else begin
          r = res_q.pop_front();
          chk("result_kind", 32'(err), 32'(r.kind));
          if (r.anchor != 0) begin
            ref_cyc = (r.anchor == 1) ? acc_cyc : (r.anchor == 2) ? den_cyc : fall_cyc;
            chk("result_latency", 32'(cyc - ref_cyc), 32'(r.lat));
          end
        end
        idle_next = 1;
      end
    end
  end

  // Stimulus
  initial begin
    int sel, d;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_sel    = 3'd0;
    req_divide = 7'd0;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    #3;
    check_reset("por");
    repeat (3) @(posedge dclk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge dclk);
    #1;
    check_reset("idle");

    mem['h08] = 16'hF000;
    mem['h09] = 16'h00C0;
    issue(0, 10, 0);
    mem['h15] = 16'hAB3F;
    issue(6, 1, 0);
    issue(7, 10, 0);
    issue(2, 0, 0);
    issue(3, 65, 0);
    issue(4, 64, 0);
    issue(1, 7, 1);
    chk("ready_after_drdy_to", 32'(req_ready), 1);
    issue(5, 12, 2);
    issue(3, 20, 3);
    issue(2, 3, 0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: begin sel = 7; d = $urandom_range(1, 64); end
          1: begin sel = $urandom_range(0, 6); d = 0; end
          default: begin sel = $urandom_range(0, 6); d = $urandom_range(65, 127); end
        endcase
      end else begin
        sel = $urandom_range(0, 6);
        d   = $urandom_range(1, 64);
      end
      issue(sel, d, 0);
    end
    repeat (5) @(posedge dclk);
    finish_run();
  end

endmodule
